instr_fetch_seq: RTL and testbench

Instruction fetch sequencer that feeds 32-bit MIPS instruction words into the `DataPath` `instruction` input. A program is preloaded into internal instruction memory through a write port. On `start`, the block issues words 0..`end_addr` in order and inserts NOP (all-zero) bubbles between them for hazard spacing. It is the producer side of the datapath instruction interface and replaces hand-driven instruction streams.

---
 rtl/instr_fetch_seq.sv | 118 +++++++++++
 tb/tb_instr_fetch_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: plays a preloaded program into the datapath with NOP spacing.
// Optional macro IF_BUBBLE_EN enables the BUBBLE state; without it words issue back-to-back.
module instr_fetch_seq #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int BUBBLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              stall,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              done
);

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_W");
    end
    if (BUBBLES < 1 || BUBBLES > 15) begin : g_bad_bubbles
        $error("BUBBLES must be in 1..15");
    end

`ifdef IF_BUBBLE_EN
    typedef enum logic [1:0] {IDLE, ISSUE, BUBBLE, DONE} state_t;
    localparam logic [3:0] BCNT_INIT = 4'(BUBBLES - 1);
    logic [3:0] bcnt;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] idx_nxt;
    logic              adv;
    logic              last;
    logic [31:0]       mem [DEPTH];

    assign idx_nxt = idx + ADDR_W'(1);
    assign last    = (idx == end_q);

    // The advance step fires at the end of the spacing for the current word.
`ifdef IF_BUBBLE_EN
    assign adv = !stall && (state == BUBBLE) && (bcnt == 4'd0);
`else
    assign adv = !stall && (state == ISSUE);
`endif

    assign busy        = (state != IDLE) && (state != DONE);
    assign instr_valid = (state == ISSUE);
    assign done        = (state == DONE);

    // Memory is not reset; writes only land while the sequencer is idle.
    always_ff @(posedge CLK) begin
        if (state == IDLE && prog_we)
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            instruction <= '0;
            pc          <= '0;
            idx         <= '0;
            end_q       <= '0;
`ifdef IF_BUBBLE_EN
            bcnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        end_q       <= end_addr;
                        idx         <= '0;
                        pc          <= '0;
                        instruction <= mem[0];
                        state       <= ISSUE;
                    end
                end
`ifdef IF_BUBBLE_EN
                ISSUE: begin
                    if (!stall) begin
                        instruction <= '0;
                        bcnt        <= BCNT_INIT;
                        state       <= BUBBLE;
                    end
                end
                BUBBLE: begin
                    if (!stall && bcnt != 4'd0)
                        bcnt <= bcnt - 4'd1;
                end
`endif
                DONE: state <= IDLE;
                default: ;
            endcase

            if (adv) begin
                if (last) begin
                    instruction <= '0;
                    state       <= DONE;
                end else begin
                    idx         <= idx_nxt;
                    pc          <= pc + 32'd4;
                    instruction <= mem[idx_nxt];
                    state       <= ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: trace model of each run plus directed literal checks.
// Two instances share all inputs: BUBBLES=1 (u0) and BUBBLES=3 (u1).
module tb_instr_fetch_seq;

    logic        CLK = 1'b0;
    logic        RST, start, stall, prog_we;
    logic [5:0]  end_addr, prog_addr;
    logic [31:0] prog_data;
    logic [31:0] instr0, pc0, instr1, pc1;
    logic        v0, b0, d0, v1, b1, d1;

    always #5 CLK = ~CLK;

    instr_fetch_seq #(.DEPTH(64), .ADDR_W(6), .BUBBLES(1)) u0 (
        .CLK(CLK), .RST(RST), .start(start), .end_addr(end_addr), .stall(stall),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instruction(instr0), .instr_valid(v0), .pc(pc0), .busy(b0), .done(d0));

    instr_fetch_seq #(.DEPTH(64), .ADDR_W(6), .BUBBLES(3)) u1 (
        .CLK(CLK), .RST(RST), .start(start), .end_addr(end_addr), .stall(stall),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instruction(instr1), .instr_valid(v1), .pc(pc1), .busy(b1), .done(d1));

`ifdef IF_BUBBLE_EN
    localparam int BUB0 = 1;
    localparam int BUB1 = 3;
`else
    localparam int BUB0 = 0;
    localparam int BUB1 = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] prog [5] = '{32'h01E9A022, 32'h0289A022, 32'h00AF7820,
                              32'h012F7820, 32'h028FA82A};
    logic [31:0] tb_mem [64];

    logic [31:0] exp_i [512];
    logic [31:0] exp_pc [512];
    logic        exp_v [512];
    logic        exp_b [512];
    logic        exp_d [512];
    logic [31:0] obs_i [512];
    logic [31:0] obs_pc [512];
    logic        obs_d [512];
    int          exp_len = 0;
    int          ptr = 0;
    bit          chk_on = 1'b0;
    int          sel_r = 0;

    logic [31:0] a_i, a_pc;
    logic        a_v, a_b, a_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    // Per-cycle comparison of the selected instance against the model trace.
    always @(posedge CLK) begin
        #1;
        if (chk_on && ptr < exp_len) begin
            a_i  = (sel_r == 1) ? instr1 : instr0;
            a_pc = (sel_r == 1) ? pc1 : pc0;
            a_v  = (sel_r == 1) ? v1 : v0;
            a_b  = (sel_r == 1) ? b1 : b0;
            a_d  = (sel_r == 1) ? d1 : d0;
            chk($sformatf("instruction[%0d]", ptr), a_i, exp_i[ptr]);
            chk($sformatf("pc[%0d]", ptr), a_pc, exp_pc[ptr]);
            chk($sformatf("instr_valid[%0d]", ptr), {31'b0, a_v}, {31'b0, exp_v[ptr]});
            chk($sformatf("busy[%0d]", ptr), {31'b0, a_b}, {31'b0, exp_b[ptr]});
            chk($sformatf("done[%0d]", ptr), {31'b0, a_d}, {31'b0, exp_d[ptr]});
            obs_i[ptr]  = a_i;
            obs_pc[ptr] = a_pc;
            obs_d[ptr]  = a_d;
            ptr++;
            if (ptr >= exp_len) chk_on = 1'b0;
        end
    end

    // Builds the expected trace from the run rules, then drives the run.
    // sw/sl: stall word sw for sl extra cycles; wcyc: cycle of an ignored write;
    // abort_at: truncate checking at that cycle (caller resets); wr_start: write mem[0] with start.
    task automatic run(input int s, input int e, input int sw, input int sl, input int wcyc,
                       input int abort_at, input bit wr_start, input logic [31:0] wr_data);
        int t = 0;
        int tstall = -1;
        int bub = (s == 1) ? BUB1 : BUB0;
        for (int w = 0; w <= e; w++) begin
            if (w == sw) tstall = t;
            for (int h = 0; h < 1 + ((w == sw) ? sl : 0); h++) begin
                exp_i[t] = tb_mem[w]; exp_pc[t] = 32'(4 * w);
                exp_v[t] = 1'b1; exp_b[t] = 1'b1; exp_d[t] = 1'b0; t++;
            end
            for (int b = 0; b < bub; b++) begin
                exp_i[t] = 32'h0; exp_pc[t] = 32'(4 * w);
                exp_v[t] = 1'b0; exp_b[t] = 1'b1; exp_d[t] = 1'b0; t++;
            end
        end
        exp_i[t] = 32'h0; exp_pc[t] = 32'(4 * e); exp_v[t] = 1'b0; exp_b[t] = 1'b0; exp_d[t] = 1'b1; t++;
        exp_i[t] = 32'h0; exp_pc[t] = 32'(4 * e); exp_v[t] = 1'b0; exp_b[t] = 1'b0; exp_d[t] = 1'b0; t++;
        if (abort_at >= 0) t = abort_at + 1;

        @(negedge CLK);
        sel_r    = s;
        end_addr = 6'(e);
        start    = 1'b1;
        if (wr_start) begin
            prog_we = 1'b1; prog_addr = 6'd0; prog_data = wr_data;
            tb_mem[0] = wr_data;
        end
        ptr     = 0;
        exp_len = t;
        chk_on  = 1'b1;
        for (int c = 0; c < t; c++) begin
            @(negedge CLK);
            start   = 1'b0;
            prog_we = 1'b0;
            stall   = (sl > 0 && c >= tstall && c < tstall + sl);
            if (c == wcyc) begin
                prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'hDEADBEEF;
            end
        end
        stall   = 1'b0;
        prog_we = 1'b0;
        if (abort_at < 0) begin
            for (int w = 0; w < 5 && chk_on; w++) @(negedge CLK);
            if (chk_on) begin
                n_cmp++; n_bad++;
                $display("FAIL run_timeout: actual ptr %0d required %0d", ptr, exp_len);
                chk_on = 1'b0;
            end
            repeat (24) @(negedge CLK);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; start = 1'b0; stall = 1'b0; prog_we = 1'b0;
        end_addr = '0; prog_addr = '0; prog_data = '0;
        repeat (2) @(negedge CLK);
        chk("rst_instr", instr0, 32'h0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_busy", {31'b0, b0}, 32'h0);
        chk("rst_valid", {31'b0, v0}, 32'h0);
        chk("rst_done", {31'b0, d0}, 32'h0);
        chk("rst_busy_u1", {31'b0, b1}, 32'h0);
        RST = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            prog_we = 1'b1; prog_addr = 6'(i); prog_data = prog[i];
            tb_mem[i] = prog[i];
        end
        @(negedge CLK);
        prog_we = 1'b0;
        repeat (2) @(negedge CLK);

        // Load and run
        run(0, 4, -1, 0, -1, -1, 1'b0, 32'h0);
        chk("lit_first", obs_i[0], 32'h01E9A022);
`ifdef IF_BUBBLE_EN
        chk("lit_bubble1", obs_i[1], 32'h0);
        chk("lit_word1", obs_i[2], 32'h0289A022);
        chk("lit_word4", obs_i[8], 32'h028FA82A);
        chk("lit_pc4", obs_pc[8], 32'd16);
        chk("lit_done11", {31'b0, obs_d[10]}, 32'h1);
`else
        chk("lit_word1", obs_i[1], 32'h0289A022);
        chk("lit_word4", obs_i[4], 32'h028FA82A);
        chk("lit_done6", {31'b0, obs_d[5]}, 32'h1);
`endif

        // Stall on word 2 for three cycles
        run(0, 4, 2, 3, -1, -1, 1'b0, 32'h0);
`ifdef IF_BUBBLE_EN
        chk("lit_stall_hold", obs_i[7], 32'h00AF7820);
        chk("lit_stall_pc", obs_pc[7], 32'd8);
        chk("lit_stall_after", obs_i[8], 32'h0);
        chk("lit_stall_next", obs_i[9], 32'h012F7820);
`else
        chk("lit_stall_hold", obs_i[5], 32'h00AF7820);
        chk("lit_stall_next", obs_i[6], 32'h012F7820);
`endif

        // Reset mid-run, then restart
        run(0, 4, -1, 0, -1, (BUB0 > 0) ? 3 : 1, 1'b0, 32'h0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_instr", instr0, 32'h0);
        chk("abort_busy", {31'b0, b0}, 32'h0);
        chk("abort_pc", pc0, 32'h0);
        chk("abort_valid", {31'b0, v0}, 32'h0);
        repeat (2) @(negedge CLK);
        run(0, 4, -1, 0, -1, -1, 1'b0, 32'h0);
        chk("lit_restart", obs_i[0], 32'h01E9A022);

        // Single word, with an ignored write during the run
        run(0, 0, -1, 0, 0, -1, 1'b0, 32'h0);
        run(0, 0, -1, 0, -1, -1, 1'b0, 32'h0);
        chk("lit_single", obs_i[0], 32'h01E9A022);
`ifdef IF_BUBBLE_EN
        chk("lit_single_done", {31'b0, obs_d[2]}, 32'h1);
`else
        chk("lit_single_done", {31'b0, obs_d[1]}, 32'h1);
`endif

        // Write with start: old mem[0] issues, new value seen next run
        run(0, 1, -1, 0, -1, -1, 1'b1, 32'h11111111);
        chk("lit_rbw_old", obs_i[0], 32'h01E9A022);
        run(0, 0, -1, 0, -1, -1, 1'b0, 32'h0);
        chk("lit_rbw_new", obs_i[0], 32'h11111111);
        @(negedge CLK);
        prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'h01E9A022;
        tb_mem[0] = 32'h01E9A022;
        @(negedge CLK);
        prog_we = 1'b0;

        // Multiple bubbles on the BUBBLES=3 instance
        run(1, 1, -1, 0, -1, -1, 1'b0, 32'h0);
        chk("lit_mb_first", obs_i[0], 32'h01E9A022);
`ifdef IF_BUBBLE_EN
        chk("lit_mb_gap", obs_i[3], 32'h0);
        chk("lit_mb_word1", obs_i[4], 32'h0289A022);
        chk("lit_mb_done", {31'b0, obs_d[8]}, 32'h1);
`else
        chk("lit_mb_word1", obs_i[1], 32'h0289A022);
        chk("lit_mb_done", {31'b0, obs_d[2]}, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
